// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter output path.
// Contents:
//   ARB_DATA_WIDTH - default payload width for arbiter-path blocks.
//   ptr_width()    - pointer width for a power-of-two queue.
//                    The result is index bits plus one wrap bit.
package arb_pkg;

    localparam int unsigned ARB_DATA_WIDTH = 16;

    // Extra MSB lets equal indices be told apart as full or empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arb_out_fifo.sv
// First-word fall-through output FIFO that sits behind the arbiter.
// Ports:
//   aclk, areset        - clock; synchronous active-high reset.
//   prev_valid_i/_ready_o/_data_i - upstream (arbiter) handshake and payload.
//   next_valid_o/_ready_i/_data_o - downstream handshake and head payload.
//   count_o             - occupancy, 0..DEPTH.
//   full_o, empty_o     - occupancy == DEPTH / == 0.
// Every status output comes from registered pointers only.
// prev_ready_o therefore never sees next_ready_i, so a full FIFO cannot pass a word through.
module arb_out_fifo
    import arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     prev_valid_i,
    output logic                     prev_ready_o,
    input  logic [DATA_WIDTH-1:0]    prev_data_i,
    output logic                     next_valid_o,
    input  logic                     next_ready_i,
    output logic [DATA_WIDTH-1:0]    next_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned IdxW = PtrW - 1;

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IdxW-1:0]       wr_idx, rd_idx;
    logic                  push, pop;

    assign wr_idx = wr_ptr_q[IdxW-1:0];
    assign rd_idx = rd_ptr_q[IdxW-1:0];

    // Indices equal with wrap bits differing means the writer has lapped the reader.
    assign full_o  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) && (wr_idx == rd_idx);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign prev_ready_o = !full_o;
    assign next_valid_o = !empty_o;
    assign next_data_o  = empty_o ? '0 : mem_q[rd_idx];

    assign push = prev_valid_i && prev_ready_o;
    assign pop  = next_valid_o && next_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage has no reset; the reset pointers hide any stale contents.
    always_ff @(posedge aclk) begin
        if (push && !areset) begin
            mem_q[wr_idx] <= prev_data_i;
        end
    end

endmodule

// File: tb/tb_arb_out_fifo.sv
// Self-checking bench for arb_out_fifo.
// A queue model predicts every output before and after each clock edge.
module tb_arb_out_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic          prev_valid_i;
    logic          prev_ready_o;
    logic [DW-1:0] prev_data_i;
    logic          next_valid_o;
    logic          next_ready_i;
    logic [DW-1:0] next_data_o;
    logic [2:0]    count_o;
    logic          full_o;
    logic          empty_o;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];

    always #5 aclk = ~aclk;

    arb_out_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .prev_valid_i (prev_valid_i),
        .prev_ready_o (prev_ready_o),
        .prev_data_i  (prev_data_i),
        .next_valid_o (next_valid_o),
        .next_ready_i (next_ready_i),
        .next_data_o  (next_data_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ":count"}, 32'(count_o), 32'(n));
        chk({tag, ":full"}, 32'(full_o), 32'(n == DEPTH));
        chk({tag, ":empty"}, 32'(empty_o), 32'(n == 0));
        chk({tag, ":prev_ready"}, 32'(prev_ready_o), 32'(n < DEPTH));
        chk({tag, ":next_valid"}, 32'(next_valid_o), 32'(n != 0));
        chk({tag, ":next_data"}, 32'(next_data_o), (n != 0) ? 32'(q[0]) : 32'h0);
    endtask

    // Drives one cycle: checks outputs before the edge, updates the model, checks after it.
    task automatic do_cycle(input logic rst, input logic v, input logic [DW-1:0] d,
                            input logic r, input string tag);
        logic do_push, do_pop;
        areset       = rst;
        prev_valid_i = v;
        prev_data_i  = d;
        next_ready_i = r;
        #1;
        check_all({tag, "/pre"});
        @(posedge aclk);
        if (rst) begin
            q.delete();
        end else begin
            do_push = v && (q.size() < DEPTH);
            do_pop  = r && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        #1;
        check_all({tag, "/post"});
    endtask

    initial begin
        areset       = 1'b1;
        prev_valid_i = 1'b0;
        prev_data_i  = '0;
        next_ready_i = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        q.delete();
        areset = 1'b0;

        // Idle after reset.
        check_all("reset_idle");
        chk("reset_data_lit", 32'(next_data_o), 32'h0);

        // Fill with downstream stalled; the fifth push must be dropped.
        do_cycle(1'b0, 1'b1, 16'hAAAA, 1'b0, "fill0");
        do_cycle(1'b0, 1'b1, 16'hBBBB, 1'b0, "fill1");
        do_cycle(1'b0, 1'b1, 16'hAAAA, 1'b0, "fill2");
        do_cycle(1'b0, 1'b1, 16'hBBBB, 1'b0, "fill3");
        chk("full_count_lit", 32'(count_o), 32'd4);
        chk("full_ready_lit", 32'(prev_ready_o), 32'd0);
        do_cycle(1'b0, 1'b1, 16'h1234, 1'b0, "push_when_full");
        chk("full_head_lit", 32'(next_data_o), 32'hAAAA);

        // No pass-through: ready stays low while full even when downstream is ready.
        areset       = 1'b0;
        prev_valid_i = 1'b1;
        prev_data_i  = 16'h5555;
        next_ready_i = 1'b1;
        #1;
        chk("full_no_passthru", 32'(prev_ready_o), 32'd0);

        // Drain in order.
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, "drain0");
        chk("drain_head1_lit", 32'(next_data_o), 32'hBBBB);
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, "drain1");
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, "drain2");
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, "drain3");
        chk("drained_empty_lit", 32'(empty_o), 32'd1);
        chk("drained_data_lit", 32'(next_data_o), 32'h0);

        // Fall-through latency: nothing visible before the push edge.
        do_cycle(1'b0, 1'b1, 16'hAAAA, 1'b0, "latency");
        chk("latency_valid_lit", 32'(next_valid_o), 32'd1);
        chk("latency_data_lit", 32'(next_data_o), 32'hAAAA);

        // Reach count 2, then push and pop together across pointer wrap.
        do_cycle(1'b0, 1'b1, 16'h0001, 1'b0, "pre_stream");
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, 1'b1, 16'(16'h0100 + i), 1'b1, "stream");
        end
        chk("stream_count_lit", 32'(count_o), 32'd2);

        // Reset with three words stored and handshakes active.
        do_cycle(1'b0, 1'b1, 16'hC0DE, 1'b0, "pre_rst");
        chk("pre_rst_count_lit", 32'(count_o), 32'd3);
        do_cycle(1'b1, 1'b1, 16'hDEAD, 1'b1, "mid_reset");
        chk("mid_reset_count_lit", 32'(count_o), 32'd0);
        do_cycle(1'b0, 1'b1, 16'h7777, 1'b0, "post_rst_push");
        chk("post_rst_head_lit", 32'(next_data_o), 32'h7777);
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, "post_rst_pop");

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                     16'($urandom), ($urandom_range(0, 2) != 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arb_out_fifo.md
ARB_OUT_FIFO -- requirements
Module: arb_out_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16, payload width in bits.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 aclk  input  1  single clock; all state updates on rising edge.
REQ-004 areset  input  1  reset, synchronous, active-high.
REQ-005 prev_valid_i  input  1  upstream (arbiter) word valid.
REQ-006 prev_ready_o  output  1  FIFO can accept a word this cycle.
REQ-007 prev_data_i  input  DATA_WIDTH  upstream payload.
REQ-008 next_valid_o  output  1  head word valid to downstream.
REQ-009 next_ready_i  input  1  downstream accepts head word.
REQ-010 next_data_o  output  DATA_WIDTH  head payload.
REQ-011 count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 full_o / empty_o  output  1 each  occupancy == DEPTH / == 0.

Function
REQ-013 Push occurs on a rising edge iff prev_valid_i && prev_ready_o; pop iff next_valid_o && next_ready_i.
REQ-014 prev_ready_o shall equal !full_o; it shall not depend combinationally on next_ready_i (no pass-through when full).
REQ-015 next_valid_o shall equal !empty_o; first-word fall-through: head word visible combinationally from storage.
REQ-016 Latency: a word pushed into an empty FIFO at edge N shall appear on next_valid_o/next_data_o after edge N (cycle N+1); no same-cycle bypass.
REQ-017 next_data_o shall be all-zeros while empty_o = 1.
REQ-018 Order shall be strict FIFO; no word dropped, duplicated or reordered.
REQ-019 While next_valid_o && !next_ready_i, next_data_o and next_valid_o shall hold stable.
REQ-020 Write and read pointers are $clog2(DEPTH)+1 bits; index = low bits; wrap at DEPTH with MSB toggle; full when indices equal and MSBs differ, empty when pointers equal.
REQ-021 Simultaneous push and pop (0 < count < DEPTH): both occur, count unchanged.
REQ-022 Full: pop allowed, push blocked; ready re-asserts the cycle after the pop edge.
REQ-023 Empty: pop impossible; push only; count increments.
REQ-024 count_o, full_o, empty_o shall be registered or derived from registered pointers only, never from current-cycle inputs.
REQ-025 prev_valid_i while prev_ready_o = 0 shall not alter state.

Reset
REQ-026 While areset = 1 at a rising edge: pointers 0, count_o 0, empty_o 1, full_o 0, next_valid_o 0, prev_ready_o 1, next_data_o 0 from the following cycle.
REQ-027 Reset mid-operation discards all stored words; handshakes in the reset cycle are ignored.
REQ-028 Storage array is not reset.

Structure
REQ-029 Shared package arb_pkg holds DATA_WIDTH default and the pointer-width function/typedef used by arbiter-path blocks.
REQ-030 No sub-module; storage, pointers and flags are inline in arb_out_fifo.

Verification
REQ-031 Reset for 3 cycles, then idle -> next_valid_o 0, prev_ready_o 1, count_o 0, next_data_o 16'h0000.
REQ-032 next_ready_i 0, push 16'hAAAA,16'hBBBB,16'hAAAA,16'hBBBB -> count_o 4, full_o 1, prev_ready_o 0, fifth push ignored, head stays 16'hAAAA.
REQ-033 From full, next_ready_i 1 for 4 cycles, no push -> outputs AAAA,BBBB,AAAA,BBBB in order, then empty_o 1, next_data_o 16'h0000.
REQ-034 count_o 2, push and pop every cycle for 10 cycles -> count_o stays 2, order preserved across pointer wrap.
REQ-035 Push 16'hAAAA into empty FIFO at edge N -> next_valid_o 0 before edge N, 1 with 16'hAAAA after it.
REQ-036 Assert areset with count_o 3 -> next cycle count_o 0, empty_o 1, previously stored words never emitted.
